// File: rtl/mlp_pkg.sv
// Shared definitions for the PU layer front end.
//   - c_state_e : compute FSM encoding (idle, PU restart, PU run, result handoff)
//   - NUM_BANKS : number of frame banks used for double buffering
package mlp_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_START = 2'd1,
        C_RUN   = 2'd2,
        C_DONE  = 2'd3
    } c_state_e;

endpackage

// File: rtl/pu_input_loader_if.sv
// Serial sample stream into the PU input loader.
//   in_data  : sample value (n bits, two's complement, stored unaltered)
//   in_valid : sample present
//   in_last  : sample is the final one of its frame
//   in_ready : loader can accept a sample this cycle
// master = sample producer, slave = loader.
interface pu_input_loader_if #(
    parameter int n = 8
) ();

    logic [n-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/frame_bank.sv
// One frame bank: number_of_input slots of n bits each.
//   clk, rst : clock and synchronous active-high clear of every slot
//   we_i     : write data_i into slot idx_i at the rising edge
//   idx_i    : slot index
//   data_i   : sample to store
//   bank_o   : whole bank as a flat bus, slot i at bits [i*n +: n]
module frame_bank #(
    parameter int n                     = 8,
    parameter int number_of_input       = 62,
    parameter int clog2_number_of_input = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we_i,
    input  logic [clog2_number_of_input-1:0] idx_i,
    input  logic [n-1:0]                     data_i,
    output logic [number_of_input*n-1:0]     bank_o
);

    logic [number_of_input*n-1:0] mem_q;
    logic [number_of_input*n-1:0] mem_d;

    // Slot write: only the addressed slot changes.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[idx_i*n +: n] = data_i;
        end else begin
            mem_d = mem_q;
        end
    end

    // Bank storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= {(number_of_input*n){1'b0}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bank_o = mem_q;

endmodule

// File: rtl/pu_input_loader.sv
// Writer-side front end for a layer of PU neurons.
// Collects number_of_input samples per frame into one of two banks, then
// restarts the PUs, enables them until they report ready, and releases the
// bank. The other bank keeps loading while the current frame computes.
//   clk, rst   : clock, synchronous active-high reset
//   in_if      : sample stream (data/valid/last in, ready out)
//   datas      : frame of the bank being computed, sample i at [i*n +: n]
//   pu_rst     : PU restart (also held during rst)
//   pu_clk_en  : PU clock enable while running
//   pu_ready   : PU result-ready flag
//   layer_done : one-cycle pulse, results valid and frame released
//   busy       : compute side active
//   frame_err  : sticky framing error (short frame or missing last)
module pu_input_loader
    import mlp_pkg::*;
#(
    parameter int n                     = 8,
    parameter int number_of_input       = 62,
    parameter int clog2_number_of_input = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    pu_input_loader_if.slave             in_if,
    output logic [number_of_input*n-1:0] datas,
    output logic                         pu_rst,
    output logic                         pu_clk_en,
    input  logic                         pu_ready,
    output logic                         layer_done,
    output logic                         busy,
    output logic                         frame_err
);

    localparam logic [clog2_number_of_input-1:0] LAST_IDX =
        clog2_number_of_input'(number_of_input - 1);

    c_state_e                         state_q, state_d;
    logic [NUM_BANKS-1:0]             full_q, full_d;
    logic                             wr_bank_q, wr_bank_d;
    logic                             rd_bank_q, rd_bank_d;
    logic [clog2_number_of_input-1:0] wr_cnt_q, wr_cnt_d;
    logic                             frame_err_q, frame_err_d;

    logic                             in_ready_s;
    logic                             hs_s;
    logic [NUM_BANKS-1:0]             bank_we_s;
    logic [number_of_input*n-1:0]     bank_data_s [NUM_BANKS];

    assign in_ready_s     = ~rst & ~full_q[wr_bank_q];
    assign in_if.in_ready = in_ready_s;
    assign hs_s           = in_if.in_valid & in_ready_s;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_we_s[b] = hs_s & (wr_bank_q == 1'(b));

        frame_bank #(
            .n                     (n),
            .number_of_input       (number_of_input),
            .clog2_number_of_input (clog2_number_of_input)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .we_i   (bank_we_s[b]),
            .idx_i  (wr_cnt_q),
            .data_i (in_if.in_data),
            .bank_o (bank_data_s[b])
        );
    end

    // Fill side and bank ownership. A completing handshake never targets the
    // bank being released: the write bank is empty, the released bank is full.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        frame_err_d = frame_err_q;
        full_d      = full_q;
        if (hs_s) begin
            if (wr_cnt_q == LAST_IDX) begin
                // Slot count alone closes a frame; a missing last is flagged.
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = {clog2_number_of_input{1'b0}};
                wr_bank_d         = ~wr_bank_q;
                if (!in_if.in_last) begin
                    frame_err_d = 1'b1;
                end else begin
                    frame_err_d = frame_err_q;
                end
            end else if (in_if.in_last) begin
                // Short frame: drop it and refill the same bank from slot 0.
                wr_cnt_d    = {clog2_number_of_input{1'b0}};
                frame_err_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (state_q == C_DONE) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d[rd_bank_q] = full_d[rd_bank_q];
        end
    end

    // Compute FSM next state and read-bank advance.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        case (state_q)
            C_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = C_START;
                end else begin
                    state_d = C_IDLE;
                end
            end
            C_START: state_d = C_RUN;
            C_RUN: begin
                if (pu_ready) begin
                    state_d = C_DONE;
                end else begin
                    state_d = C_RUN;
                end
            end
            C_DONE: begin
                state_d   = C_IDLE;
                rd_bank_d = ~rd_bank_q;
            end
            default: state_d = C_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= C_IDLE;
            full_q      <= {NUM_BANKS{1'b0}};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= {clog2_number_of_input{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign datas      = bank_data_s[rd_bank_q];
    assign pu_rst     = rst | (state_q == C_START);
    assign pu_clk_en  = (state_q == C_RUN);
    assign layer_done = (state_q == C_DONE);
    assign busy       = (state_q != C_IDLE);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pu_input_loader.sv
// Self-checking bench for pu_input_loader: a table of single-stream frame
// scenarios, hand-written corner sequences, and a randomized run, all checked
// every cycle against a frame-queue reference model.
module tb_pu_input_loader;

    localparam int N  = 8;
    localparam int NI = 62;
    localparam int W  = NI * N;
    localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pu_ready = 1'b0;
    logic [W-1:0] datas;
    logic         pu_rst, pu_clk_en, layer_done, busy, frame_err;

    pu_input_loader_if #(.n(N)) bus ();

    pu_input_loader #(
        .n                     (N),
        .number_of_input       (NI),
        .clog2_number_of_input (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .datas      (datas),
        .pu_rst     (pu_rst),
        .pu_clk_en  (pu_clk_en),
        .pu_ready   (pu_ready),
        .layer_done (layer_done),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit check_en = 1'b0, auto_ready = 1'b0, got_hs = 1'b0;
    int en_cnt = 0, rst_pulses = 0, ld_cnt = 0, stall_cnt = 0;
    int first_rst_cyc = -1, last_hs_cyc = -1;
    logic [W-1:0] cap_datas, ld_datas;

    // Reference model: completed-but-unreleased frames in arrival order,
    // the partial frame being collected, the compute phase and the error flag.
    logic [W-1:0] m_frames[$];
    logic [7:0]   m_part[$];
    int           m_phase = PH_IDLE;
    bit           m_err = 1'b0, m_clean = 1'b1;

    task automatic chk_b(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_i(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int old_sz;
        int nph;
        bit pop;
        logic [W-1:0] f;
        if (rst) begin
            m_frames.delete();
            m_part.delete();
            m_phase = PH_IDLE;
            m_err   = 1'b0;
            m_clean = 1'b1;
            return;
        end
        old_sz = m_frames.size();
        nph = m_phase;
        pop = 1'b0;
        case (m_phase)
            PH_IDLE:  if (old_sz > 0) nph = PH_START;
            PH_START: nph = PH_RUN;
            PH_RUN:   if (pu_ready) nph = PH_DONE;
            default:  begin nph = PH_IDLE; pop = 1'b1; end
        endcase
        if (bus.in_valid && old_sz < 2) begin
            m_clean = 1'b0;
            m_part.push_back(bus.in_data);
            if (m_part.size() == NI) begin
                for (int i = 0; i < NI; i++) f[i*8 +: 8] = m_part[i];
                m_frames.push_back(f);
                m_part.delete();
                if (!bus.in_last) m_err = 1'b1;
            end else if (bus.in_last) begin
                m_part.delete();
                m_err = 1'b1;
            end
        end
        if (pop) void'(m_frames.pop_front());
        m_phase = nph;
    endtask

    // One clock cycle: inputs already set; compare at the falling edge,
    // advance the model at the rising edge.
    task automatic step();
        if (auto_ready) pu_ready = (en_cnt >= 10);
        @(negedge clk);
        if (check_en) begin
            chk_b("in_ready", bus.in_ready, !rst && (m_frames.size() < 2));
            chk_b("pu_rst", pu_rst, rst || (m_phase == PH_START));
            chk_b("pu_clk_en", pu_clk_en, m_phase == PH_RUN);
            chk_b("layer_done", layer_done, m_phase == PH_DONE);
            chk_b("busy", busy, m_phase != PH_IDLE);
            chk_b("frame_err", frame_err, m_err);
            if (m_frames.size() > 0) chk_w("datas", datas, m_frames[0]);
            else if (m_clean) chk_w("datas_zero", datas, {W{1'b0}});
        end
        got_hs = bus.in_valid && bus.in_ready;
        if (pu_rst && !rst) begin
            if (first_rst_cyc < 0) first_rst_cyc = cyc;
            rst_pulses++;
            cap_datas = datas;
        end
        if (layer_done) begin
            ld_cnt++;
            ld_datas = datas;
        end
        en_cnt = pu_clk_en ? en_cnt + 1 : 0;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 8'h00;
        pu_ready = 1'b0;
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_b("rst_in_ready", bus.in_ready, 1'b1);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_frame_err", frame_err, 1'b0);
        chk_b("rst_pu_rst", pu_rst, 1'b0);
        chk_w("rst_datas", datas, {W{1'b0}});
    endtask

    task automatic send_sample(logic [7:0] d, logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int t = 0; t < 400; t++) begin
            step();
            if (got_hs) begin
                last_hs_cyc = cyc - 1;
                return;
            end
            stall_cnt++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no handshake expected handshake within 400 cycles");
    endtask

    task automatic send_frame(logic [7:0] base, int inc, int len, int last_pos);
        for (int k = 0; k < len; k++) send_sample(8'(base + inc * k), k == last_pos);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_ld(int target);
        for (int t = 0; t < 2000; t++) begin
            if (ld_cnt >= target) return;
            step();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL layer_done_timeout: got %0d expected %0d", ld_cnt, target);
    endtask

    typedef struct {
        int         len;
        int         last_pos;
        logic [7:0] base;
        int         exp_runs;
        logic       exp_err;
        logic [7:0] exp_slot0;
    } vec_t;

    vec_t tbl[6];
    logic [W-1:0] f_exp, fill11, fill22;

    initial begin
        tbl[0] = '{62,  61, 8'h01, 1, 1'b0, 8'h01};  // clean frame 1..62
        tbl[1] = '{5,    4, 8'h40, 0, 1'b1, 8'h00};  // short frame
        tbl[2] = '{62,  -1, 8'h80, 1, 1'b1, 8'h80};  // missing last
        tbl[3] = '{62,  30, 8'h10, 0, 1'b1, 8'h00};  // early last mid-frame
        tbl[4] = '{124, 61, 8'hF0, 2, 1'b1, 8'h2E};  // second frame lacks last
        tbl[5] = '{67,   4, 8'h00, 1, 1'b1, 8'h05};  // short then full frame
        for (int i = 0; i < NI; i++) begin
            fill11[i*8 +: 8] = 8'h11;
            fill22[i*8 +: 8] = 8'h22;
        end

        for (int v = 0; v < 6; v++) begin
            do_reset();
            auto_ready = 1'b1;
            rst_pulses = 0;
            ld_cnt = 0;
            first_rst_cyc = -1;
            send_frame(tbl[v].base, 1, tbl[v].len, tbl[v].last_pos);
            repeat (40) step();
            chk_i("runs", ld_cnt, tbl[v].exp_runs);
            chk_i("pu_rst_pulses", rst_pulses, tbl[v].exp_runs);
            chk_b("table_frame_err", frame_err, tbl[v].exp_err);
            if (tbl[v].exp_runs > 0) begin
                for (int i = 0; i < NI; i++)
                    f_exp[i*8 +: 8] = 8'(int'(tbl[v].base) + tbl[v].len - NI + i);
                chk_w("frame_data", cap_datas, f_exp);
                chk_i("slot0", int'(cap_datas[7:0]), int'(tbl[v].exp_slot0));
            end
            if (v == 0) chk_i("latency", first_rst_cyc - last_hs_cyc, 2);
        end

        // Double buffering: B loads without stalls while A waits for pu_ready.
        do_reset();
        auto_ready = 1'b0;
        send_frame(8'h11, 0, NI, NI - 1);
        stall_cnt = 0;
        send_frame(8'h22, 0, NI, NI - 1);
        chk_i("b_stalls", stall_cnt, 0);
        step();
        chk_w("datas_A_held", datas, fill11);
        auto_ready = 1'b1;
        ld_cnt = 0;
        wait_ld(1);
        chk_w("datas_at_A_done", ld_datas, fill11);
        chk_w("datas_after_A", datas, fill22);
        wait_ld(2);

        // Back-pressure with both banks full.
        do_reset();
        auto_ready = 1'b0;
        send_frame(8'h31, 1, NI, NI - 1);
        send_frame(8'h93, 1, NI, NI - 1);
        chk_b("bp_full_ready", bus.in_ready, 1'b0);
        repeat (5) step();
        chk_b("bp_still_blocked", bus.in_ready, 1'b0);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        chk_b("bp_done", layer_done, 1'b1);
        chk_b("bp_ready_r1", bus.in_ready, 1'b0);
        step();
        chk_b("bp_ready_r2", bus.in_ready, 1'b1);

        // Reset while the PUs are running.
        do_reset();
        auto_ready = 1'b0;
        send_frame(8'h70, 1, NI, NI - 1);
        for (int t = 0; t < 20; t++) begin
            if (pu_clk_en) break;
            step();
        end
        chk_b("run_reached", pu_clk_en, 1'b1);
        rst = 1'b1;
        step();
        chk_b("mid_rst_clk_en", pu_clk_en, 1'b0);
        chk_b("mid_rst_pu_rst", pu_rst, 1'b1);
        chk_w("mid_rst_datas", datas, {W{1'b0}});
        rst = 1'b0;
        step();
        chk_b("post_rst_ready", bus.in_ready, 1'b1);
        chk_b("post_rst_pu_rst", pu_rst, 1'b0);
        chk_b("post_rst_busy", busy, 1'b0);

        // Randomized traffic checked every cycle by the model.
        do_reset();
        auto_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data = 8'($urandom);
            if (m_part.size() == NI - 1) bus.in_last = ($urandom_range(0, 15) != 0);
            else bus.in_last = ($urandom_range(0, 79) == 0);
            pu_ready = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
